// File: rtl/wb_stream_writer_dma.sv
// wb_stream_writer_dma: memory-to-stream DMA.
// A Wishbone read master fetches a buffer from memory in incrementing bursts
// and pushes each returned word into a small FIFO. The FIFO drives a
// valid/ready stream master.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   wbm_*                      Wishbone B4 read master (registered cyc/stb/adr/cti)
//   stream_m_*                 stream master fed from the internal FIFO
//   enable                     rising edge starts a transfer; low stops after the current burst
//   start_adr/buf_size         buffer byte address and length in words
//   burst_size                 words per burst (0 -> 1, clamped to MAX_BURST_LEN)
//   busy/tx_cnt/irq/err        status: running, words read, done pulse, sticky bus error
module wb_stream_writer_dma #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    input  logic               enable,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    output logic               busy,
    output logic [WB_AW-1:0]   tx_cnt,
    output logic               irq,
    output logic               err
);

    localparam int               DEPTH   = 2**FIFO_AW;
    localparam logic [WB_AW-1:0] BYTES   = WB_AW'(WB_DW/8);
    localparam logic [WB_AW-1:0] MAX_BL  = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ONE     = WB_AW'(1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               enable_q;
    logic [WB_AW-1:0]   start_adr_q, start_adr_d;
    logic [WB_AW-1:0]   buf_size_q, buf_size_d;
    logic [WB_AW-1:0]   burst_eff_q, burst_eff_d;
    logic [WB_AW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [WB_AW-1:0]   beats_q, beats_d;
    logic [WB_AW-1:0]   adr_q, adr_d;
    logic [2:0]         cti_q, cti_d;
    logic               cyc_q, cyc_d;
    logic               busy_q, busy_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [WB_DW-1:0]   mem_q [DEPTH];

    logic [WB_AW-1:0]   remain, burst_len;
    logic [FIFO_AW:0]   fifo_free;
    logic               push, pop;

    always_comb begin
        remain    = buf_size_q - tx_cnt_q;
        burst_len = (burst_eff_q < remain) ? burst_eff_q : remain;
        fifo_free = DEPTH_C - cnt_q;
        // An errored beat is never stored, even if ack arrives with it.
        push      = (state_q == S_BURST) && wbm_ack_i && !wbm_err_i;
        pop       = (cnt_q != '0) && stream_m_ready_i;

        state_d     = state_q;
        start_adr_d = start_adr_q;
        buf_size_d  = buf_size_q;
        burst_eff_d = burst_eff_q;
        tx_cnt_d    = tx_cnt_q;
        beats_d     = beats_q;
        adr_d       = adr_q;
        cti_d       = cti_q;
        cyc_d       = cyc_q;
        busy_d      = busy_q;
        irq_d       = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !enable_q) begin
                    start_adr_d = start_adr;
                    buf_size_d  = buf_size;
                    if (burst_size == '0)        burst_eff_d = ONE;
                    else if (burst_size > MAX_BL) burst_eff_d = MAX_BL;
                    else                          burst_eff_d = burst_size;
                    tx_cnt_d = '0;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    if (buf_size == '0) state_d = S_DONE;
                end else if (busy_q) begin
                    if (enable && tx_cnt_q < buf_size_q) state_d = S_WAIT;
                    else                                 busy_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (WB_AW'(fifo_free) >= burst_len) begin
                    // Whole burst fits now; pops can only add room, so no push overflows.
                    cyc_d   = 1'b1;
                    adr_d   = start_adr_q + tx_cnt_q * BYTES;
                    beats_d = burst_len;
                    cti_d   = (burst_len == ONE) ? 3'b111 : 3'b010;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (wbm_err_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = 3'b000;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (wbm_ack_i) begin
                    tx_cnt_d = tx_cnt_q + ONE;
                    adr_d    = adr_q + BYTES;
                    beats_d  = beats_q - ONE;
                    if (beats_q == ONE) begin
                        cyc_d   = 1'b0;
                        cti_d   = 3'b000;
                        state_d = (tx_cnt_q + ONE == buf_size_q) ? S_DONE : S_WAIT;
                    end else if (beats_q == 2 * ONE) begin
                        cti_d = 3'b111;  // next beat is the last one
                    end
                end
            end
            S_DONE: begin
                irq_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            start_adr_q <= '0;
            buf_size_q  <= '0;
            burst_eff_q <= '0;
            tx_cnt_q    <= '0;
            beats_q     <= '0;
            adr_q       <= '0;
            cti_q       <= 3'b000;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable;
            start_adr_q <= start_adr_d;
            buf_size_q  <= buf_size_d;
            burst_eff_q <= burst_eff_d;
            tx_cnt_q    <= tx_cnt_d;
            beats_q     <= beats_d;
            adr_q       <= adr_d;
            cti_q       <= cti_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            if (push) mem_q[wr_ptr_q] <= wbm_dat_i;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = 2'b00;

    assign stream_m_valid_o = (cnt_q != '0);
    assign stream_m_data_o  = stream_m_valid_o ? mem_q[rd_ptr_q] : '0;

    assign busy   = busy_q;
    assign tx_cnt = tx_cnt_q;
    assign irq    = irq_q;
    assign err    = err_q;

endmodule

// File: tb/tb_wb_stream_writer_dma.sv
// Bench for wb_stream_writer_dma (FIFO_AW=2, so MAX_BURST_LEN=4).
// A random-latency Wishbone slave returns memval(adr); the expected stream is
// built up front from start_adr/buf_size, and bus beats are checked against
// burst lengths derived from min(burst_eff, words remaining).
module tb_wb_stream_writer_dma;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int FAW = 2;
    localparam int MAXB = 1 << FAW;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_o;
    logic [DW/8-1:0] sel_o;
    logic            we_o, cyc_o, stb_o;
    logic [2:0]      cti_o;
    logic [1:0]      bte_o;
    logic [DW-1:0]   dat_i = '0;
    logic            ack_i = 1'b0, err_i = 1'b0;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            ready = 1'b0;
    logic            enable;
    logic [AW-1:0]   start_adr, buf_size, burst_size;
    logic            busy, irq, err;
    logic [AW-1:0]   tx_cnt;

    wb_stream_writer_dma #(.WB_DW(DW), .WB_AW(AW), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_sel_o(sel_o), .wbm_we_o(we_o),
        .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_cti_o(cti_o), .wbm_bte_o(bte_o),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack_i), .wbm_err_i(err_i),
        .stream_m_data_o(s_data), .stream_m_valid_o(s_valid), .stream_m_ready_i(ready),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
        .busy(busy), .tx_cnt(tx_cnt), .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int xfer_id = 0, err_beat = -1, ack_mode = 0, ready_mode = 1;
    int irq_cnt = 0, bursts = 0, irq_base = 0, burst_base = 0;
    logic [31:0] seed = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] m_start = 32'h0;
    int m_buf = 0, m_eff = 1, m_tx = 0, m_len = 0, m_beat = 0;
    int last_id = 0;
    bit prev_cyc = 1'b0, err_chk = 1'b0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Wishbone slave + bus-side model, decided at the falling edge.
    initial forever begin
        @(negedge clk);
        if (xfer_id != last_id) begin
            last_id = xfer_id;
            m_tx    = 0;
        end
        ack_i = 1'b0;
        err_i = 1'b0;
        if (err_chk) begin
            chk("cyc_drop_after_err", 32'(cyc_o), 32'd0);
            err_chk = 1'b0;
        end
        if (cyc_o === 1'b1) begin
            if (!prev_cyc) begin
                m_len  = (m_eff < m_buf - m_tx) ? m_eff : m_buf - m_tx;
                m_beat = 0;
                bursts++;
            end
            chk("stb_eq_cyc", 32'(stb_o), 32'd1);
            chk("beat_adr", adr_o, m_start + 32'(4 * m_tx));
            chk("beat_cti", 32'(cti_o), (m_beat == m_len - 1) ? 32'd7 : 32'd2);
            chk("beat_in_burst", 32'(m_beat < m_len), 32'd1);
            if (ack_mode == 1 || ($urandom % 3) != 0) begin
                if (m_tx == err_beat) begin
                    err_i   = 1'b1;
                    err_chk = 1'b1;
                end else begin
                    ack_i = 1'b1;
                    dat_i = memval(adr_o);
                    m_tx++;
                    m_beat++;
                end
            end
        end
        prev_cyc = (cyc_o === 1'b1);
    end

    // Stream sink: every accepted word must be the next expected memory word.
    initial forever begin
        @(negedge clk);
        if (s_valid === 1'b1 && ready === 1'b1) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL stream_extra_word: observed %h expected none", s_data);
            end
            if (exp_q.size() != 0) chk("stream_word", s_data, exp_q.pop_front());
        end
        if (irq === 1'b1) irq_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
    end

    // Caller is at posedge+1 with enable low.
    task automatic start_xfer(input logic [31:0] sa, input int bsz, input int brst,
                              input int n_exp, input int eb);
        m_start  = sa;
        m_buf    = bsz;
        m_eff    = (brst == 0) ? 1 : ((brst > MAXB) ? MAXB : brst);
        err_beat = eb;
        seed     = $urandom;
        for (int i = 0; i < n_exp; i++) exp_q.push_back(memval(sa + 32'(4 * i)));
        xfer_id++;
        irq_base   = irq_cnt;
        burst_base = bursts;
        start_adr  = sa;
        buf_size   = 32'(bsz);
        burst_size = 32'(brst);
        enable     = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_xfer(input int e_tx, input int e_irq, input int e_bursts, input logic e_err);
        int k = 0;
        while (busy === 1'b1 && k < 3000) begin @(posedge clk); #1; k++; end
        chk("busy_fall_timeout", 32'(k < 3000), 32'd1);
        chk("tx_cnt", tx_cnt, 32'(e_tx));
        chk("err_flag", 32'(err), 32'(e_err));
        enable     = 1'b0;
        ready_mode = 1;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
        repeat (3) begin @(posedge clk); #1; end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("valid_after_drain", 32'(s_valid), 32'd0);
        chk("irq_pulses", 32'(irq_cnt - irq_base), 32'(e_irq));
        chk("burst_count", 32'(bursts - burst_base), 32'(e_bursts));
    endtask

    initial begin
        int k, bs, br, eff;
        logic [31:0] sa;
        rst = 1'b1; enable = 1'b0;
        start_adr = '0; buf_size = '0; burst_size = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_tx_cnt", tx_cnt, 32'd0);
        chk("rst_sel", 32'(sel_o), 32'hF);
        chk("rst_adr", adr_o, 32'd0);
        chk("rst_irq_err", {30'd0, irq, err}, 32'd0);
        chk("rst_tieoffs", {dat_o[27:0], we_o, bte_o, stb_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two full bursts of 4.
        start_xfer(32'h1000, 8, 4, 8, -1);
        finish_xfer(8, 1, 2, 1'b0);

        // 4 + single-beat tail, random sink.
        ready_mode = 2;
        start_xfer(32'h2000, 5, 4, 5, -1);
        finish_xfer(5, 1, 2, 1'b0);

        // FIFO full holds the second burst until the sink drains it.
        ready_mode = 0;
        start_xfer(32'h3000, 8, 4, 8, -1);
        repeat (30) begin @(posedge clk); #1; end
        chk("full_hold_cyc", 32'(cyc_o), 32'd0);
        chk("full_hold_tx", tx_cnt, 32'd4);
        chk("full_hold_busy", 32'(busy), 32'd1);
        chk("full_hold_valid", 32'(s_valid), 32'd1);
        ready_mode = 1;
        finish_xfer(8, 1, 2, 1'b0);

        // Bus error on the 3rd beat.
        start_xfer(32'h4000, 8, 4, 2, 2);
        finish_xfer(2, 0, 1, 1'b1);

        // Enable dropped during the first burst; new start clears err.
        start_xfer(32'h5000, 16, 4, 4, -1);
        chk("err_cleared_on_start", 32'(err), 32'd0);
        k = 0;
        while (cyc_o !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
        chk("cyc_rise_timeout", 32'(k < 100), 32'd1);
        enable = 1'b0;
        finish_xfer(4, 0, 1, 1'b0);

        // Empty buffer: no bus cycle, irq only.
        start_xfer(32'h6000, 0, 4, 0, -1);
        finish_xfer(0, 1, 0, 1'b0);

        // Random sizes, burst 0 and >MAX included.
        for (int t = 0; t < 8; t++) begin
            bs  = $urandom_range(1, 12);
            br  = $urandom_range(0, 6);
            sa  = {14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
            eff = (br == 0) ? 1 : ((br > MAXB) ? MAXB : br);
            ready_mode = 2;
            start_xfer(sa, bs, br, bs, -1);
            finish_xfer(bs, 1, (bs + eff - 1) / eff, 1'b0);
        end

        // Reset in the middle of a burst with 2 words buffered.
        ready_mode = 0;
        ack_mode   = 1;
        start_xfer(32'h8000, 8, 4, 0, -1);
        k = 0;
        while (!(tx_cnt == 32'd2 && cyc_o === 1'b1) && k < 100) begin @(posedge clk); #1; k++; end
        chk("mid_burst_timeout", 32'(k < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cyc", 32'(cyc_o), 32'd0);
        chk("midrst_valid", 32'(s_valid), 32'd0);
        chk("midrst_tx_cnt", tx_cnt, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; enable = 1'b0; ack_mode = 0;
        exp_q.delete();
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst_no_irq", 32'(irq_cnt - irq_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
